// File: rtl/clk_div_multi_if.sv
`default_nettype none
// ============================================================================
// Module      : clk_div_multi_if
// Description : Control and output bundle for the multi-channel clock divider.
// Revision    : 1.0 - initial release
// ============================================================================
interface clk_div_multi_if #(
    parameter int CH  = 4,
    parameter int W   = 8,
    parameter int CHW = (CH > 1) ? $clog2(CH) : 1
);
    logic           en;
    logic           wr_en;
    logic [CHW-1:0] wr_ch;
    logic [W-1:0]   wr_div;
    logic           sync;
    logic [CH-1:0]  clk_out;
    logic [CH-1:0]  tick;
    logic [CH-1:0]  upd_pending;

    modport master (
        output en, wr_en, wr_ch, wr_div, sync,
        input  clk_out, tick, upd_pending
    );

    modport slave (
        input  en, wr_en, wr_ch, wr_div, sync,
        output clk_out, tick, upd_pending
    );
endinterface
`default_nettype wire

// File: rtl/clk_div_multi.sv
`default_nettype none
// ============================================================================
// Module      : clk_div_multi
// Description : CH independent programmable clock dividers with glitch-free
//               runtime divisor changes and a common phase re-align input.
// Revision    : 1.0 - initial release
// ============================================================================
module clk_div_multi #(
    parameter int CH      = 4,
    parameter int W       = 8,
    parameter int DEF_DIV = 8
) (
    input  wire               clk,
    input  wire               rst,
    clk_div_multi_if.slave    bus
);
    localparam int           CHW   = (CH > 1) ? $clog2(CH) : 1;
    localparam logic [W-1:0] c_def = W'(DEF_DIV);
    localparam logic [W-1:0] c_one = W'(1);
    localparam logic [W-1:0] c_two = W'(2);

    logic [CH-1:0] w_clk_out;
    logic [CH-1:0] w_tick;
    logic [CH-1:0] w_pending;

    for (genvar i = 0; i < CH; i++) begin : g_ch
        localparam logic [CHW-1:0] c_ch = CHW'(i);

        logic [W-1:0] r_div;
        logic [W-1:0] r_pdiv;
        logic [W-1:0] r_cnt;
        logic         r_pend;
        logic         r_clk;
        logic         r_tick;

        logic         w_wr;
        logic         w_active;
        logic         w_wrap;
        logic [W-1:0] w_cnt_inc;
        logic [W-1:0] w_sync_div;
        logic [W-1:0] w_sync_cnt;
        logic [W-1:0] w_pend_cnt;

        always_comb begin
            w_wr       = bus.wr_en && (bus.wr_ch == c_ch);
            w_active   = (r_div >= c_two);
            w_wrap     = (r_cnt == r_div - c_one);
            w_cnt_inc  = w_wrap ? '0 : r_cnt + c_one;
            w_sync_div = w_wr ? bus.wr_div : (r_pend ? r_pdiv : r_div);
            // A channel left at divisor 0/1 parks its counter at zero.
            w_sync_cnt = (w_sync_div >= c_two) ? w_sync_div - c_one : '0;
            w_pend_cnt = (r_pdiv >= c_two) ? r_pdiv - c_one : '0;
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                r_div  <= c_def;
                r_pdiv <= c_def;
                r_pend <= 1'b0;
                r_cnt  <= c_def - c_one;
                r_clk  <= 1'b0;
                r_tick <= 1'b0;
            end else if (bus.sync) begin
                // Counter parked on the last phase so the next enabled edge rises.
                r_div  <= w_sync_div;
                r_pdiv <= w_sync_div;
                r_pend <= 1'b0;
                r_cnt  <= w_sync_cnt;
                r_clk  <= 1'b0;
                r_tick <= 1'b0;
            end else if (!w_active) begin
                r_clk  <= 1'b0;
                r_tick <= 1'b0;
                if (r_pend) begin
                    r_div  <= r_pdiv;
                    r_cnt  <= w_pend_cnt;
                    r_pend <= w_wr;
                end else begin
                    r_cnt <= '0;
                end
                if (w_wr) begin
                    r_pdiv <= bus.wr_div;
                    r_pend <= 1'b1;
                end
            end else if (!bus.en) begin
                r_tick <= 1'b0;
                if (w_wr) begin
                    r_pdiv <= bus.wr_div;
                    r_pend <= 1'b1;
                end
            end else if (w_wrap && r_pend) begin
                r_div  <= r_pdiv;
                r_cnt  <= '0;
                r_clk  <= (r_pdiv >= c_two);
                r_tick <= (r_pdiv >= c_two);
                r_pend <= w_wr;
                if (w_wr) begin
                    r_pdiv <= bus.wr_div;
                end
            end else begin
                r_cnt  <= w_cnt_inc;
                r_clk  <= (w_cnt_inc < (r_div >> 1));
                r_tick <= (w_cnt_inc == '0);
                if (w_wr) begin
                    r_pdiv <= bus.wr_div;
                    r_pend <= 1'b1;
                end
            end
        end

        assign w_clk_out[i] = r_clk;
        assign w_tick[i]    = r_tick;
        assign w_pending[i] = r_pend;
    end

    assign bus.clk_out     = w_clk_out;
    assign bus.tick        = w_tick;
    assign bus.upd_pending = w_pending;
endmodule
`default_nettype wire

// File: tb/tb_clk_div_multi.sv
`default_nettype none
// ============================================================================
// Module      : tb_clk_div_multi
// Description : Scoreboard bench for clk_div_multi with a per-channel model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_clk_div_multi;
    localparam int CH      = 4;
    localparam int W       = 8;
    localparam int DEF_DIV = 8;
    localparam int CHW     = (CH > 1) ? $clog2(CH) : 1;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    clk_div_multi_if #(.CH(CH), .W(W)) bus ();

    clk_div_multi #(.CH(CH), .W(W), .DEF_DIV(DEF_DIV)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual %0h required %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: each channel is a phase position inside its period.
    logic [3*CH-1:0] expq[$];
    int m_d[CH], m_p[CH], m_pend[CH], m_ph[CH], m_co[CH], m_tk[CH];

    initial begin
        logic s_rst, s_en, s_wr_en, s_sync;
        int   s_ch, s_div;
        logic [CH-1:0] e_clk, e_tick, e_pend;
        bit   wr;
        int   nd;
        forever begin
            @(posedge clk);
            s_rst = rst; s_en = bus.en; s_wr_en = bus.wr_en; s_sync = bus.sync;
            s_ch = int'(bus.wr_ch); s_div = int'(bus.wr_div);
            for (int c = 0; c < CH; c++) begin
                wr = s_wr_en && (s_ch == c);
                if (s_rst) begin
                    m_d[c] = DEF_DIV; m_p[c] = DEF_DIV; m_pend[c] = 0;
                    m_ph[c] = DEF_DIV - 1; m_co[c] = 0; m_tk[c] = 0;
                end else if (s_sync) begin
                    nd = wr ? s_div : (m_pend[c] != 0 ? m_p[c] : m_d[c]);
                    m_d[c] = nd; m_p[c] = nd; m_pend[c] = 0;
                    m_ph[c] = (nd >= 2) ? nd - 1 : 0;
                    m_co[c] = 0; m_tk[c] = 0;
                end else if (m_d[c] < 2) begin
                    m_co[c] = 0; m_tk[c] = 0;
                    if (m_pend[c] != 0) begin
                        m_d[c] = m_p[c]; m_pend[c] = 0;
                        m_ph[c] = (m_p[c] >= 2) ? m_p[c] - 1 : 0;
                    end else m_ph[c] = 0;
                    if (wr) begin m_p[c] = s_div; m_pend[c] = 1; end
                end else if (!s_en) begin
                    m_tk[c] = 0;
                    if (wr) begin m_p[c] = s_div; m_pend[c] = 1; end
                end else begin
                    if (m_ph[c] == m_d[c] - 1 && m_pend[c] != 0) begin
                        m_d[c] = m_p[c]; m_pend[c] = 0; m_ph[c] = 0;
                    end else begin
                        m_ph[c] = (m_ph[c] + 1) % m_d[c];
                    end
                    if (m_d[c] < 2) begin
                        m_ph[c] = 0; m_co[c] = 0; m_tk[c] = 0;
                    end else begin
                        m_co[c] = (m_ph[c] < m_d[c] / 2) ? 1 : 0;
                        m_tk[c] = (m_ph[c] == 0) ? 1 : 0;
                    end
                    if (wr) begin m_p[c] = s_div; m_pend[c] = 1; end
                end
                e_clk[c]  = (m_co[c] != 0);
                e_tick[c] = (m_tk[c] != 0);
                e_pend[c] = (m_pend[c] != 0);
            end
            expq.push_back({e_pend, e_tick, e_clk});
        end
    end

    // Monitor: one expected entry per clock edge.
    initial begin
        logic [3*CH-1:0] e;
        forever begin
            @(posedge clk);
            #1;
            if (expq.size() == 0) begin
                errors++;
                $display("FAIL scoreboard_empty actual 0 entries required 1 at %0t", $time);
            end else begin
                e = expq.pop_front();
                chk("clk_out",     32'(bus.clk_out),     32'(e[CH-1:0]));
                chk("tick",        32'(bus.tick),        32'(e[2*CH-1:CH]));
                chk("upd_pending", 32'(bus.upd_pending), 32'(e[3*CH-1:2*CH]));
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wr(input int ch, input int div);
        bus.wr_en  = 1'b1;
        bus.wr_ch  = CHW'(ch);
        bus.wr_div = W'(div);
        @(negedge clk);
        bus.wr_en  = 1'b0;
    endtask

    initial begin
        checks = 0; errors = 0;
        rst = 1'b1; bus.en = 1'b1; bus.wr_en = 1'b0; bus.wr_ch = '0;
        bus.wr_div = '0; bus.sync = 1'b0;
        idle(2);
        chk("rst_clk_out", 32'(bus.clk_out), 32'h0);
        chk("rst_tick",    32'(bus.tick),    32'h0);
        chk("rst_pending", 32'(bus.upd_pending), 32'h0);
        rst = 1'b0;
        idle(1);
        chk("edge1_clk_out", 32'(bus.clk_out), 32'hF);
        chk("edge1_tick",    32'(bus.tick),    32'hF);
        idle(1);
        chk("edge2_tick",    32'(bus.tick),    32'h0);
        chk("edge2_clk_out", 32'(bus.clk_out), 32'hF);
        idle(3);
        chk("edge5_clk_out", 32'(bus.clk_out), 32'h0);
        idle(4);
        chk("edge9_tick",    32'(bus.tick),    32'hF);

        idle(2);
        wr(1, 5);
        chk("ch1_pending", 32'(bus.upd_pending[1]), 32'h1);
        idle(20);
        wr(2, 3);
        idle(1);
        wr(2, 6);
        idle(20);
        wr(3, 0);
        idle(12);
        chk("ch3_disabled", 32'(bus.clk_out[3]), 32'h0);
        wr(3, 4);
        idle(12);
        wr(0, 4);
        wr(1, 6);
        idle(29);
        bus.sync = 1'b1;
        idle(1);
        bus.sync = 1'b0;
        chk("sync_low", 32'(bus.clk_out), 32'h0);
        idle(1);
        chk("sync_rise", 32'(bus.tick), 32'hF);
        idle(14);
        wr(0, 20);
        bus.sync = 1'b1;
        idle(1);
        bus.sync = 1'b0;
        idle(2);
        bus.en = 1'b0;
        idle(10);
        bus.en = 1'b1;
        idle(30);
        rst = 1'b1;
        idle(1);
        rst = 1'b0;
        chk("mid_rst_clk_out", 32'(bus.clk_out), 32'h0);
        idle(5);

        for (int n = 0; n < 4000; n++) begin
            bus.en     = ($urandom_range(0, 9) != 0);
            bus.sync   = ($urandom_range(0, 99) == 0);
            rst        = ($urandom_range(0, 499) == 0);
            bus.wr_en  = ($urandom_range(0, 9) == 0);
            bus.wr_ch  = CHW'($urandom_range(0, (1 << CHW) - 1));
            bus.wr_div = ($urandom_range(0, 3) == 0) ? W'($urandom_range(0, 40))
                                                     : W'($urandom_range(0, 12));
            @(negedge clk);
        end
        rst = 1'b0; bus.en = 1'b1; bus.sync = 1'b0; bus.wr_en = 1'b0;
        idle(2);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/clk_div_multi.md
# clk_div_multi

Multi-channel programmable clock divider. It is the parametrised successor to the fixed divide-by-4/8 dividers in the clocking area. From the single system clock it generates CH independent divided-clock outputs and matching one-cycle rising-edge ticks. Each channel's divisor can be changed at runtime without glitches, and a sync input re-aligns the phase of all channels. All logic runs on the posedge of clk; outputs are registered and intended as enables or slow strobes for downstream logic.

## Interface
- CH, 4: number of divider channels (1..16).
- W, 8: divisor width in bits; maximum divisor is 2^W-1.
- DEF_DIV, 8: divisor loaded into every channel at reset (must be ≥2 and <2^W).
- clk  in  1  system clock; all state updates on its rising edge.
- rst  in  1  reset, synchronous, active-high; has priority over every other input.
- en  in  1  global count enable; when low, all channel state holds.
- wr_en  in  1  divisor write strobe, one cycle.
- wr_ch  in  max(1,$clog2(CH))  target channel for the write; values ≥CH are ignored.
- wr_div  in  W  new divisor value.
- sync  in  1  phase re-align pulse for all channels.
- clk_out  out  CH  divided clock per channel, registered.
- tick  out  CH  one-cycle pulse in the cycle where clk_out[i] rises.
- upd_pending  out  CH  a written divisor is waiting to take effect.

## Operation
- Per-channel state:
  - active divisor D (W bits)
  - pending divisor P and pending flag
  - counter cnt (W bits, range 0..D-1)
  - clk_out and tick registers.
- High time is H = D>>1 cycles; low time is D-H. Even D gives 50% duty. Odd D is high for floor(D/2) cycles and low for the rest.
- Active channel (D ≥ 2) with en=1, on each edge:
  - cnt_nxt = (cnt==D-1) ? 0 : cnt+1
  - clk_out <= (cnt_nxt < H)
  - tick <= (cnt_nxt == 0)
- Disabled channel (D of 0 or 1): cnt, clk_out and tick are held at 0.
- Divisor write: wr_en with a valid wr_ch sets P=wr_div and the pending flag.
  - A later write before the change applies overwrites P. Only the last value applies.
  - Pending is applied at the wrap edge (cnt==D-1 with en=1): D<=P, cnt<=0, and clk_out/tick are evaluated against the new D and H. The pending flag clears on that edge.
  - If the current D is below 2, pending is applied on the next edge regardless of en: D<=P, cnt<=P-1, clk_out=0. The output starts on the following enabled edge.
  - Writing 0 or 1 disables the channel at its next wrap.
- sync=1 acts on every channel regardless of en:
  - any pending value is applied
  - cnt<=D-1, clk_out<=0, tick<=0
  - pending flags clear.
  - The next enabled edge then drives all active channels high together, with tick asserted.
- en=0: cnt, clk_out and D hold; tick is forced to 0; writes still capture into P. A pending apply waits for the wrap edge, except on disabled channels.
- Simultaneous events:
  - rst beats sync, and sync beats wrap.
  - wr_en in the same cycle as sync to the same channel: the written value is applied by the sync.
  - wr_en in the same cycle as a wrap apply: the old P is applied, and the new value becomes pending.
- Reset: D=DEF_DIV, P=DEF_DIV, cnt=DEF_DIV-1, clk_out=0, tick=0, upd_pending=0.

## Timing
- After rst deasserts with en=1, the first enabled edge gives clk_out=1 and tick=1 on all channels, so channels are phase-aligned out of reset.
- clk_out period is exactly D clk cycles with no glitches, including across divisor changes. The period immediately before a change is the complete old period.
- A tick accompanies every clk_out rising edge and lasts exactly one clk cycle.
- upd_pending rises one cycle after wr_en and falls on the apply edge.
- Reset mid-operation drops clk_out to 0 on the next edge, even mid-high-phase.

## Test plan
- Reset with DEF_DIV=8, en=1: every clk_out is high for 4 cycles and low for 4, period 8; ticks land at cycles 1, 9, 17 after reset release.
- Write div=5 to ch1 mid-period: the old 8-cycle period completes, then ch1 runs high 2 and low 3; upd_pending[1] is high from the write until the wrap.
- Write 3, then 6 to ch2 within one period: only 6 applies; high 3, low 3.
- Write 0 to ch3: ch3 holds 0 after its wrap. Then write 4: ch3 starts on the second edge after the write (high 2, low 2), with a tick on its first rise.
- Set ch0=4 and ch1=6 and let them drift; pulse sync: both go low, then rise together on the next edge with ticks coincident.
- Drop en for 10 cycles mid-high-phase: clk_out holds high and tick stays 0; on resume, the period continues from the frozen cnt. Assert rst mid-phase: all outputs are 0 on the next edge.
